in_n_out_sequencer: RTL
=======================

# in_n_out_sequencer

Sequencer that drives the three-input/two-output combinational block `simple_in_n_out` through its input code space.
- Steps a 3-bit code from 0 to `LAST_CODE` and holds each code for a programmable dwell time.
- Samples the two outputs at the end of each dwell and packs them into a result vector.
- Signals completion with a one-cycle `done` pulse.
- Sits beside the datapath as its on-chip stimulus/capture controller, replacing bench-driven stimulus.

## Interface
Parameters:
- `DWELL`, 4: cycles each code is held before its sample cycle; legal 1..255.
- `LAST_CODE`, 7: final code applied; legal 0..7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `abort` in 1: stop an active sweep.
- `in_1`, `in_2`, `in_3` out 1 each: drive the datapath. `in_1 = code[0]`, `in_2 = code[1]`, `in_3 = code[2]`.
- `out_1`, `out_2` in 1 each: datapath outputs, sampled.
- `busy` out 1: high in APPLY and SAMPLE.
- `done` out 1: one-cycle pulse on sweep completion.
- `code` out 3: current code.
- `result` out 16: bits `[2k+1:2k]` = `{out_2,out_1}` captured for code k.
- `result_valid` out 8: bit k set once code k has been captured.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- **IDLE:**
  - `in_*`, `code`, `busy`, `done` are 0.
  - On `start & !abort`: clear `result` and `result_valid`, load code 0, load the dwell timer with `DWELL-1`, go to APPLY.
- **APPLY:**
  - Drive `in_*` from `code`; decrement the timer.
  - When the timer is 0, go to SAMPLE.
- **SAMPLE** (exactly one cycle):
  - Write `{out_2,out_1}` into `result` slot `code`; set `result_valid[code]`.
  - If `code == LAST_CODE`, go to DONE.
  - Otherwise increment `code`, reload the timer, and go to APPLY.
- **DONE:** `done=1` for one cycle, `in_*` and `code` return to 0, go to IDLE.
- **abort** in APPLY/SAMPLE/DONE:
  - Next state is IDLE and `in_*` return to 0.
  - No `done` pulse.
  - `result`/`result_valid` keep what was captured. An abort in the SAMPLE cycle still completes that capture.
- **Priorities:** `rst` > `abort` > `start`. `start` outside IDLE is ignored.
- **Code arithmetic:** 3-bit. With `LAST_CODE=7`, `code` is never incremented past 7; no wrap occurs.
- **Reset:** all outputs 0, state IDLE, `result` = 0, `result_valid` = 0. A reset mid-sweep discards the sweep.

## Timing
- All outputs are registered.
- `start` sampled at edge N: `busy` and code 0 appear at N+1.
- Each code is on `in_*` for `DWELL+1` cycles: `DWELL` in APPLY, 1 in SAMPLE. Capture happens at the end of the SAMPLE cycle.
- `busy` is high for `(LAST_CODE+1)*(DWELL+1)` cycles. `done` is high in the following cycle, then IDLE.
- The earliest restart is `start` sampled during the cycle after `done`.
- `result_valid[k]` rises one cycle after code k's SAMPLE cycle.
- The datapath is combinational. Sampling after at least one full hold cycle requires `DWELL >= 1`.

## Structure
- Shared package `in_n_out_pkg`:
  - State enum.
  - `CODE_W=3`, `RES_W=2`, `NUM_CODES=8`.
  - Result slot index helper.
- Sub-module `in_n_out_dwell_timer`: 8-bit down-counter with `load`/`value`/`zero`. Instantiated once.
- The top level holds the FSM, code register and result registers.

## Test plan
Bench reference model: `out_1 = in_1^in_2^in_3`, `out_2 = majority(in_1,in_2,in_3)`.
- **Full sweep:** `DWELL=4`, `LAST_CODE=7`, pulse `start`.
  - `busy` high for exactly 40 cycles, then `done` for 1 cycle.
  - `result = 16'hE994`, `result_valid = 8'hFF`.
  - Each code is held 5 cycles.
- **Partial sweep:** `LAST_CODE=4`, `DWELL=1`.
  - `busy` high for 10 cycles.
  - `result = 16'h0194`, `result_valid = 8'h1F`.
  - `in_3` is high only for the final 2 busy cycles.
- **Abort:** assert `abort` during APPLY of code 3.
  - IDLE next cycle, `in_*` = 0, no `done`.
  - `result_valid = 8'h07`, `result = 16'h0014`.
- **start while busy:** pulse `start` mid-sweep → ignored; sweep timing and `result` are identical to the full-sweep case.
- **Reset and simultaneous controls:**
  - `rst` mid-sweep → next cycle all outputs 0 and `result_valid = 0`.
  - `start` and `abort` together in IDLE → stays IDLE.
- **Restart:** `start` during the cycle after `done` → `result_valid` cleared and the new sweep begins next cycle.

Source files
------------

// File: rtl/in_n_out_pkg.sv
// Shared types and constants for the in_n_out sequencer.
// State encoding, widths and result slot helper.
package in_n_out_pkg;

  localparam int CODE_W    = 3;
  localparam int RES_W     = 2;
  localparam int NUM_CODES = 8;
  localparam int TMR_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  function automatic logic [3:0] slot_lo(
    input logic [CODE_W-1:0] c
  );
    return {c, 1'b0};
  endfunction

endpackage

// File: rtl/in_n_out_dwell_timer.sv
// Dwell timer for the in_n_out sequencer.
// 8-bit down-counter, load has priority over decrement.
module in_n_out_dwell_timer
  import in_n_out_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic [TMR_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= value - TMR_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/in_n_out_sequencer.sv
// Stimulus/capture sequencer for simple_in_n_out.
// Sweeps code 0..LAST_CODE, holds each, captures outputs.
module in_n_out_sequencer
  import in_n_out_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int LAST_CODE = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic                       in_1,
  output logic                       in_2,
  output logic                       in_3,
  input  logic                       out_1,
  input  logic                       out_2,
  output logic                       busy,
  output logic                       done,
  output logic [CODE_W-1:0]          code,
  output logic [NUM_CODES*RES_W-1:0] result,
  output logic [NUM_CODES-1:0]       result_valid
);

  localparam logic [CODE_W-1:0] LAST =
    CODE_W'(LAST_CODE);
  localparam logic [TMR_W-1:0] RELOAD =
    TMR_W'(DWELL - 1);

  state_t state, state_nx;

  logic [CODE_W-1:0] code_q;
  logic              is_last;
  logic              go;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_zero;
  logic [TMR_W-1:0]  tmr_value;

  assign is_last = (code_q == LAST);
  assign go      = start & ~abort;

  assign tmr_load =
    ((state == ST_IDLE) & go) |
    ((state == ST_SAMPLE) & ~abort & ~is_last);
  assign tmr_en =
    (state == ST_APPLY) & (|tmr_value);

  in_n_out_dwell_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (RELOAD),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (go) state_nx = ST_APPLY;
      end
      ST_APPLY: begin
        if (abort)         state_nx = ST_IDLE;
        else if (tmr_zero) state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)        state_nx = ST_IDLE;
        else if (is_last) state_nx = ST_DONE;
        else              state_nx = ST_APPLY;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_APPLY:  busy = 1'b1;
      ST_SAMPLE: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  // A capture in SAMPLE completes even when aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q       <= '0;
      result       <= '0;
      result_valid <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            code_q       <= '0;
            result       <= '0;
            result_valid <= '0;
          end
        end
        ST_APPLY: begin
          if (abort) code_q <= '0;
        end
        ST_SAMPLE: begin
          result[slot_lo(code_q) +: RES_W]
            <= {out_2, out_1};
          result_valid[code_q] <= 1'b1;
          if (abort | is_last) code_q <= '0;
          else code_q <= code_q + CODE_W'(1);
        end
        ST_DONE: begin
          code_q <= '0;
        end
        default: code_q <= '0;
      endcase
    end
  end

  assign code = code_q;
  assign in_1 = code_q[0];
  assign in_2 = code_q[1];
  assign in_3 = code_q[2];

endmodule
